// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the GP register file write-back path.
package cpu_types;

   typedef logic        Clock;
   typedef logic        Bool;
   typedef logic [4:0]  RegId;
   typedef logic [31:0] Data;

   typedef struct packed {
      RegId rd;
      Data  data;
   } WbEntry;

   localparam int WB_FIFO_DEPTH = 4;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding queued long-latency write-back results.
module wb_result_fifo
   import cpu_types::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  WbEntry push_entry,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   output WbEntry head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   WbEntry        mem_q [DEPTH];
   WbEntry        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state; reset empties the queue without touching storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless while the matching slot is unoccupied.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/gp_writeback_unit.sv
// GP register file write-back producer: merges ALU, LSU and MDU results into one
// registered write port and tracks in-flight destinations for hazard detection.
module gp_writeback_unit
   import cpu_types::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic [4:0]  write_idx,
   output logic [31:0] write_data,
   output logic        write_enable,
   output logic [31:0] pending_mask
);

   // rr_mdu_q = 1 means MDU wins the next LSU/MDU contention.
   logic        rr_mdu_q, rr_mdu_d;
   logic        write_enable_q, write_enable_d;
   logic [4:0]  write_idx_q, write_idx_d;
   logic [31:0] write_data_q, write_data_d;
   logic [31:0] pending_q, pending_d;

   logic        grant_lsu, grant_mdu;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   WbEntry      push_entry, fifo_head, sel_entry;
   logic        sel_valid;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
   );

   // Round-robin enqueue; full blocks a push even when a pop frees a slot this cycle,
   // so ready never depends on alu_valid.
   always_comb begin
      grant_lsu     = lsu_valid && (!mdu_valid || !rr_mdu_q);
      grant_mdu     = mdu_valid && (!lsu_valid || rr_mdu_q);
      lsu_ready     = !reset && !fifo_full && grant_lsu;
      mdu_ready     = !reset && !fifo_full && grant_mdu;
      fifo_push     = lsu_ready || mdu_ready;
      push_entry.rd   = lsu_ready ? lsu_rd : mdu_rd;
      push_entry.data = lsu_ready ? lsu_data : mdu_data;
      rr_mdu_d      = rr_mdu_q;
      if (lsu_ready) begin
         rr_mdu_d = 1'b1;
      end else if (mdu_ready) begin
         rr_mdu_d = 1'b0;
      end
   end

   // Write-port selection: ALU first, else FIFO head; writes to x0 are dropped but still pop.
   always_comb begin
      fifo_pop       = !alu_valid && !fifo_empty;
      sel_valid      = alu_valid || !fifo_empty;
      sel_entry      = alu_valid ? {alu_rd, alu_data} : fifo_head;
      write_enable_d = sel_valid && (sel_entry.rd != '0);
      write_idx_d    = write_idx_q;
      write_data_d   = write_data_q;
      if (write_enable_d) begin
         write_idx_d  = sel_entry.rd;
         write_data_d = sel_entry.data;
      end
   end

   // Scoreboard: clear on emitted write, then set on issue so a same-edge set wins.
   always_comb begin
      pending_d = pending_q;
      if (write_enable_q) begin
         pending_d[write_idx_q] = 1'b0;
      end
      if (issue_valid) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Registered state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_mdu_q       <= 1'b0;
         write_enable_q <= 1'b0;
         write_idx_q    <= '0;
         write_data_q   <= '0;
         pending_q      <= '0;
      end else begin
         rr_mdu_q       <= rr_mdu_d;
         write_enable_q <= write_enable_d;
         write_idx_q    <= write_idx_d;
         write_data_q   <= write_data_d;
         pending_q      <= pending_d;
      end
   end

   assign write_enable = write_enable_q;
   assign write_idx    = write_idx_q;
   assign write_data   = write_data_q;
   assign pending_mask = pending_q;

   // Upstream protocol checks; violations are caller bugs and are not recovered.
   // Re-issuing a register whose clearing write is on the port this cycle is legal.
   logic issue_clears_now;
   assign issue_clears_now = write_enable_q && (write_idx_q == issue_rd);

   a_issue_not_pending: assert property (@(posedge clk) disable iff (reset)
      !(issue_valid && (issue_rd != '0) && pending_q[issue_rd] && !issue_clears_now));

   a_alu_rd_not_pending: assert property (@(posedge clk) disable iff (reset)
      !(alu_valid && pending_q[alu_rd]));

   a_lsu_rd_pending: assert property (@(posedge clk) disable iff (reset)
      !(lsu_valid && lsu_ready && !pending_q[lsu_rd]));

   a_mdu_rd_pending: assert property (@(posedge clk) disable iff (reset)
      !(mdu_valid && mdu_ready && !pending_q[mdu_rd]));

endmodule

// File: tb/tb_gp_writeback_unit.sv
module tb_gp_writeback_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic [4:0]  write_idx;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] pending_mask;

   gp_writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .mdu_valid    (mdu_valid),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .mdu_ready    (mdu_ready),
      .write_idx    (write_idx),
      .write_data   (write_data),
      .write_enable (write_enable),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: queued results, register pending set, last emitted write,
   // and which source wins the next LSU/MDU tie.
   logic [36:0] m_fifo [$];
   logic [31:0] m_pend       = '0;
   logic        m_we         = 1'b0;
   logic [4:0]  m_idx        = '0;
   logic [31:0] m_data       = '0;
   logic        m_prefer_mdu = 1'b0;
   logic        m_acc_l      = 1'b0;
   logic        m_acc_m      = 1'b0;

   logic [4:0]  lsu_wait [$];
   logic [4:0]  mdu_wait [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0; issue_rd = '0;
      alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
      lsu_valid   = 1'b0; lsu_rd   = '0; lsu_data = '0;
      mdu_valid   = 1'b0; mdu_rd   = '0; mdu_data = '0;
   endtask

   // One clock: check handshake readiness, advance the model, then check outputs after the edge.
   task automatic cycle();
      logic        full, pick_lsu, pick_mdu, exp_lr, exp_mr, sel;
      logic [4:0]  srd;
      logic [31:0] sd, np;
      logic [36:0] ent;
      #1;
      full     = (m_fifo.size() == DEPTH);
      pick_lsu = lsu_valid && (!mdu_valid || !m_prefer_mdu);
      pick_mdu = mdu_valid && (!lsu_valid || m_prefer_mdu);
      exp_lr   = !reset && !full && pick_lsu;
      exp_mr   = !reset && !full && pick_mdu;
      chk("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
      chk("mdu_ready", 32'(mdu_ready), 32'(exp_mr));
      m_acc_l = exp_lr;
      m_acc_m = exp_mr;
      if (reset) begin
         m_fifo.delete();
         m_pend = '0; m_we = 1'b0; m_idx = '0; m_data = '0; m_prefer_mdu = 1'b0;
      end else begin
         sel = 1'b0; srd = '0; sd = '0;
         if (alu_valid) begin
            sel = 1'b1; srd = alu_rd; sd = alu_data;
         end else if (m_fifo.size() > 0) begin
            ent = m_fifo.pop_front();
            sel = 1'b1; srd = ent[36:32]; sd = ent[31:0];
         end
         if (exp_lr) begin
            m_fifo.push_back({lsu_rd, lsu_data});
            m_prefer_mdu = 1'b1;
         end else if (exp_mr) begin
            m_fifo.push_back({mdu_rd, mdu_data});
            m_prefer_mdu = 1'b0;
         end
         np = m_pend;
         if (m_we) np[m_idx] = 1'b0;
         if (issue_valid) np[issue_rd] = 1'b1;
         np[0] = 1'b0;
         m_pend = np;
         m_we = sel && (srd != 5'd0);
         if (m_we) begin
            m_idx = srd; m_data = sd;
         end
      end
      @(posedge clk);
      #1;
      chk("write_enable", 32'(write_enable), 32'(m_we));
      chk("write_idx", 32'(write_idx), 32'(m_idx));
      chk("write_data", write_data, m_data);
      chk("pending_mask", pending_mask, m_pend);
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_rd = rd;
      cycle();
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   // Retire accepted LSU/MDU offers and present new ones from the outstanding lists.
   task automatic offer_results();
      if (lsu_valid && m_acc_l) begin
         void'(lsu_wait.pop_front());
         lsu_valid = 1'b0;
      end
      if (mdu_valid && m_acc_m) begin
         void'(mdu_wait.pop_front());
         mdu_valid = 1'b0;
      end
      if (!lsu_valid && lsu_wait.size() > 0 && $urandom_range(0, 2) != 0) begin
         lsu_valid = 1'b1; lsu_rd = lsu_wait[0]; lsu_data = $urandom;
      end
      if (!mdu_valid && mdu_wait.size() > 0 && $urandom_range(0, 2) != 0) begin
         mdu_valid = 1'b1; mdu_rd = mdu_wait[0]; mdu_data = $urandom;
      end
   endtask

   initial begin
      logic [4:0] r;
      int         si;
      int         guard;

      // Reset held two cycles, then released.
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_we", 32'(write_enable), 32'h0);
      chk("rst_idx", 32'(write_idx), 32'h0);
      chk("rst_data", write_data, 32'h0);
      chk("rst_pending", pending_mask, 32'h0);

      // LSU and MDU contend with ALU idle: LSU first, MDU next, writes back to back.
      issue(5'd3);
      issue(5'd4);
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
      mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h22;
      #1;
      chk("rr_lsu_first", 32'(lsu_ready), 32'h1);
      chk("rr_mdu_waits", 32'(mdu_ready), 32'h0);
      cycle();
      lsu_valid = 1'b0;
      cycle();
      mdu_valid = 1'b0;
      chk("rr_wr1_idx", 32'(write_idx), 32'd3);
      chk("rr_wr1_data", write_data, 32'h11);
      cycle();
      chk("rr_wr2_idx", 32'(write_idx), 32'd4);
      chk("rr_wr2_data", write_data, 32'h22);
      cycle();

      // Single ALU write lands exactly one cycle later.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      alu_valid = 1'b0;
      chk("alu_we", 32'(write_enable), 32'h1);
      chk("alu_idx", 32'(write_idx), 32'd5);
      chk("alu_data", write_data, 32'hDEADBEEF);
      cycle();
      chk("alu_we_once", 32'(write_enable), 32'h0);

      // ALU busy for 6 cycles while LSU streams: FIFO fills, then drains in order.
      for (int k = 0; k < 6; k++) issue(5'(10 + k));
      si = 0;
      for (int k = 0; k < 6; k++) begin
         alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = $urandom;
         lsu_valid = (si < 6); lsu_rd = 5'(10 + si); lsu_data = 32'(32'h100 + si);
         #1;
         if (k == 4) chk("lsu_ready_full", 32'(lsu_ready), 32'h0);
         cycle();
         if (m_acc_l) si++;
      end
      alu_valid = 1'b0;
      guard = 0;
      while ((si < 6 || m_fifo.size() > 0 || m_we) && guard < 30) begin
         lsu_valid = (si < 6); lsu_rd = 5'(10 + si); lsu_data = 32'(32'h100 + si);
         cycle();
         if (m_acc_l) si++;
         guard++;
      end
      lsu_valid = 1'b0;
      chk("stream_drained", 32'(guard < 30), 32'h1);

      // Scoreboard: set on issue, re-issue during the clearing write keeps the bit set.
      issue(5'd7);
      chk("sb_set", 32'(pending_mask[7]), 32'h1);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
      guard = 0;
      do begin
         cycle();
         if (m_acc_l) lsu_valid = 1'b0;
         guard++;
      end while (!(m_we && m_idx == 5'd7) && guard < 10);
      lsu_valid = 1'b0;
      chk("sb_write_seen", 32'(write_enable && write_idx == 5'd7), 32'h1);
      issue(5'd7);
      chk("sb_set_wins", 32'(pending_mask[7]), 32'h1);
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h7777;
      cycle();
      mdu_valid = 1'b0;
      cycle();
      cycle();
      cycle();
      chk("sb_cleared", 32'(pending_mask[7]), 32'h0);

      // Writes and issues to x0 are ignored.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
      issue_valid = 1'b1; issue_rd = 5'd0;
      cycle();
      clear_inputs();
      chk("x0_we", 32'(write_enable), 32'h0);
      cycle();
      chk("x0_pending", pending_mask, 32'h0);

      // Reset mid-operation discards queued results and pending bits.
      issue(5'd16);
      issue(5'd17);
      issue(5'd18);
      for (int k = 0; k < 2; k++) begin
         alu_valid = 1'b1; alu_rd = 5'(26 + k); alu_data = $urandom;
         lsu_valid = 1'b1; lsu_rd = 5'(16 + k); lsu_data = $urandom;
         cycle();
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd18;
      reset = 1'b1;
      #1;
      chk("midrst_ready", 32'(lsu_ready), 32'h0);
      cycle();
      reset = 1'b0;
      clear_inputs();
      cycle();
      chk("midrst_we", 32'(write_enable), 32'h0);
      chk("midrst_pending", pending_mask, 32'h0);
      m_acc_l = 1'b0;
      m_acc_m = 1'b0;

      // Randomized legal traffic against the model.
      for (int c = 0; c < 600; c++) begin
         offer_results();
         issue_valid = 1'b0; issue_rd = '0;
         if (c < 450 && $urandom_range(0, 1) == 1) begin
            r = 5'($urandom_range(1, 31));
            if (!m_pend[r]) begin
               issue_valid = 1'b1; issue_rd = r;
               if ($urandom_range(0, 1) == 1) lsu_wait.push_back(r);
               else mdu_wait.push_back(r);
            end
         end
         alu_valid = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            r = 5'($urandom_range(0, 31));
            if (!m_pend[r] && !(issue_valid && issue_rd == r)) begin
               alu_valid = 1'b1; alu_rd = r; alu_data = $urandom;
            end
         end
         cycle();
      end
      issue_valid = 1'b0;
      alu_valid = 1'b0;
      guard = 0;
      while ((lsu_wait.size() + mdu_wait.size() + m_fifo.size()) > 0 && guard < 300) begin
         offer_results();
         cycle();
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout observed=%0d expected=<300", guard);
      end
      clear_inputs();
      cycle();
      cycle();
      cycle();
      chk("final_pending", pending_mask, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
